bus_cmd_master: RTL and testbench

//  Upstream bus master for the m0 port of the system top (BUS/DMAC/ALU/RAM subsystem).

---
 rtl/bus_cmd_master.sv | 215 +++++++++++++++++++++
 tb/tb_bus_cmd_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: upstream req/grant bus master for the m0 port.
// Host commands are queued in a small FIFO and executed one at a time:
// bus writes, bus reads (one response each), or waits on the ALU/DMAC
// interrupt lines (one response each). Responses are single-cycle strobes.
//
// Optional feature macro: BCM_IRQ_TIMEOUT_EN
//   defined   -> an interrupt wait gives up after IRQ_TMO cycles with rsp_err=1
//   undefined -> an interrupt wait lasts until the interrupt arrives; rsp_err is 0
//
// Ports
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready         command handshake (ready = FIFO not full)
//   i_cmd_op/i_cmd_addr/i_cmd_data  00 write, 01 read, 10 wait a_int, 11 wait d_int
//   o_rsp_valid/o_rsp_data/o_rsp_err  one-cycle response, data/err held until the next
//   o_m_req/o_m_wr/o_m_address/o_m_dout, i_m_grant/i_m_din  bus master side
//   i_a_interrupt, i_d_interrupt    level interrupts from ALU and DMAC
//   o_busy                          FSM active or commands queued
module bus_cmd_master #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IRQ_TMO   = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_m_req,
  output logic              o_m_wr,
  output logic [ADDR_W-1:0] o_m_address,
  output logic [DATA_W-1:0] o_m_dout,
  input  logic              i_m_grant,
  input  logic [DATA_W-1:0] i_m_din,
  input  logic              i_a_interrupt,
  input  logic              i_d_interrupt,
  output logic              o_busy
);

  localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(CMD_DEPTH + 1);

  // Elaboration-time parameter sanity checks.
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("CMD_DEPTH must be a power of 2 and >= 2");
  end
  if (IRQ_TMO < 1) begin : g_tmo_chk
    $error("IRQ_TMO must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StReq, StRdWait, StIrqWait} state_e;

  state_e r_state, w_state_nxt;

  // Command FIFO
  logic [1:0]        r_fifo_op   [CMD_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [CMD_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [CMD_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_push, w_pop, w_empty, w_full;

  // Command being executed
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_rsp_set, w_rsp_err_nxt, w_irq_hit, w_timeout;
  logic [DATA_W-1:0] w_rsp_data_nxt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CntW'(CMD_DEPTH));
  assign o_cmd_ready = !w_full;
  assign w_push      = i_cmd_valid && !w_full;
  // Pops happen only from IDLE, which forces one idle cycle between commands.
  assign w_pop       = (r_state == StIdle) && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]   <= i_cmd_op;
      r_fifo_addr[r_wr_ptr] <= i_cmd_addr;
      r_fifo_data[r_wr_ptr] <= i_cmd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op   <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      r_op   <= r_fifo_op[r_rd_ptr];
      r_addr <= r_fifo_addr[r_rd_ptr];
      r_data <= r_fifo_data[r_rd_ptr];
    end
  end

  // op[0] selects the DMAC interrupt for waits.
  assign w_irq_hit = r_op[0] ? i_d_interrupt : i_a_interrupt;

`ifdef BCM_IRQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(IRQ_TMO + 1);
  logic [TmoW-1:0] r_wait_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || w_pop) begin
      r_wait_cnt <= '0;
    end else if (r_state == StIrqWait) begin
      r_wait_cnt <= r_wait_cnt + TmoW'(1);
    end
  end

  // Counter reaches IRQ_TMO on this edge: response appears IRQ_TMO cycles after entry.
  assign w_timeout = (r_wait_cnt == TmoW'(IRQ_TMO - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) w_state_nxt = r_fifo_op[r_rd_ptr][1] ? StIrqWait : StReq;
      end
      StReq: begin
        if (i_m_grant) w_state_nxt = r_op[0] ? StRdWait : StIdle;
      end
      StRdWait:  w_state_nxt = StIdle;
      StIrqWait: begin
        if (w_irq_hit || w_timeout) w_state_nxt = StIdle;
      end
      default:   w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_m_req        = 1'b0;
    o_m_wr         = 1'b0;
    w_rsp_set      = 1'b0;
    w_rsp_data_nxt = '0;
    w_rsp_err_nxt  = 1'b0;
    unique case (r_state)
      StIdle: ;
      StReq: begin
        o_m_req = 1'b1;
        o_m_wr  = (r_op == 2'b00);
      end
      StRdWait: begin
        o_m_req        = 1'b1;
        w_rsp_set      = 1'b1;
        w_rsp_data_nxt = i_m_din;
      end
      StIrqWait: begin
        w_rsp_set     = w_irq_hit || w_timeout;
        // Interrupt wins over a simultaneous timeout.
        w_rsp_err_nxt = !w_irq_hit && w_timeout;
      end
      default: ;
    endcase
    o_busy = (r_state != StIdle) || !w_empty;
  end

  assign o_m_address = r_addr;
  assign o_m_dout    = r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_set;
      if (w_rsp_set) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_err  <= w_rsp_err_nxt;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_bus_cmd_master.sv
// Bench for bus_cmd_master: directed scenarios followed by random commands
// against a memory/queue reference model and a randomly-granting bus slave.
module tb_bus_cmd_master;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          m_req, m_wr;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_dout;
  logic          m_grant = 1'b0;
  logic [DW-1:0] m_din = '0;
  logic          a_interrupt = 1'b0;
  logic          d_interrupt = 1'b0;
  logic          busy;

  bus_cmd_master #(
    .CMD_DEPTH(DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .IRQ_TMO  (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_data   (cmd_data),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_m_req      (m_req),
    .o_m_wr       (m_wr),
    .o_m_address  (m_address),
    .o_m_dout     (m_dout),
    .i_m_grant    (m_grant),
    .i_m_din      (m_din),
    .i_a_interrupt(a_interrupt),
    .i_d_interrupt(d_interrupt),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_slv = 1'b0;
  bit mon_en   = 1'b0;
  int n_rsp    = 0;
  int exp_total = 0;

  rsp_t          exp_q[$];
  logic [AW-1:0] bus_log[$];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer one command (called just after a negedge); updates the reference model on acceptance.
  task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    int   n;
    rsp_t e;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_val("push_timeout", 64'(cmd_ready), 64'd1);
    end else begin
      e.err = 1'b0;
      case (op)
        2'b00: mdl_mem[addr] = data;
        2'b01: begin
          e.data = mdl_mem.exists(addr) ? mdl_mem[addr] : '0;
          exp_q.push_back(e);
          exp_total++;
        end
        default: begin
          e.data = '0;
          exp_q.push_back(e);
          exp_total++;
        end
      endcase
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int bound);
    int n;
    n = 0;
    while (!m_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val("req_wait", 64'(m_req), 64'd1);
  endtask

  // Bus slave, interrupt source and response monitor for the random phase.
  initial begin : slave_mon
    bit            rd_pend;
    bit            nxt;
    logic [AW-1:0] rd_addr;
    int            a_lo, d_lo;
    rsp_t          e;
    rd_pend = 1'b0;
    rd_addr = '0;
    a_lo = 0;
    d_lo = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_val("wr_without_req", 64'(m_wr & ~m_req), 64'd0);
        if (rsp_valid) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check_val("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("rsp_data", 64'(rsp_data), 64'(e.data));
            check_val("rsp_err", 64'(rsp_err), 64'(e.err));
          end
        end
      end
      if (auto_slv) begin
        nxt   = 1'b0;
        m_din = rd_pend ? (slv_mem.exists(rd_addr) ? slv_mem[rd_addr] : '0) : $urandom;
        if (m_req && !rd_pend) begin
          m_grant = ($urandom_range(0, 2) == 0);
          if (m_grant) begin
            bus_log.push_back(m_address);
            if (m_wr) begin
              slv_mem[m_address] = m_dout;
            end else begin
              nxt     = 1'b1;
              rd_addr = m_address;
            end
          end
        end else begin
          m_grant = 1'($urandom_range(0, 1));
        end
        rd_pend = nxt;
        // Each interrupt is low at most 3 cycles in a row, so waits never reach the timeout.
        a_interrupt = (a_lo == 3) || ($urandom_range(0, 3) == 0);
        d_interrupt = (d_lo == 3) || ($urandom_range(0, 3) == 0);
        a_lo = a_interrupt ? 0 : a_lo + 1;
        d_lo = d_interrupt ? 0 : d_lo + 1;
      end else begin
        rd_pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int            hi, seen, cnt, n;
    logic [AW-1:0] pool [8];

    repeat (3) @(negedge clk);
    check_val("rst_m_req", 64'(m_req), 64'd0);
    check_val("rst_m_wr", 64'(m_wr), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_val("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_val("rst_m_address", 64'(m_address), 64'd0);
    check_val("rst_m_dout", 64'(m_dout), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Write with grant two cycles after the request
    push_cmd(2'b00, 16'h0010, 32'hDEAD_BEEF);
    wait_req(20);
    check_val("wr_m_wr", 64'(m_wr), 64'd1);
    check_val("wr_addr", 64'(m_address), 64'h0010);
    check_val("wr_dout", 64'(m_dout), 64'hDEAD_BEEF);
    hi = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(m_req);
      seen += int'(rsp_valid);
      m_grant = (i == 2);
      @(negedge clk);
    end
    m_grant = 1'b0;
    check_val("wr_req_cycles", 64'(hi), 64'd3);
    check_val("wr_no_rsp", 64'(seen), 64'd0);

    // Read with immediate grant
    push_cmd(2'b01, 16'h0020, 32'h0);
    wait_req(20);
    check_val("rd_m_wr", 64'(m_wr), 64'd0);
    check_val("rd_addr", 64'(m_address), 64'h0020);
    m_grant = 1'b1;
    m_din   = 32'hA5A5_A5A5;
    @(negedge clk);
    check_val("rd_wait_req", 64'(m_req), 64'd1);
    check_val("rd_wait_wr", 64'(m_wr), 64'd0);
    check_val("rd_wait_norsp", 64'(rsp_valid), 64'd0);
    m_grant = 1'b0;
    m_din   = 32'h1234_5678;
    @(negedge clk);
    check_val("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check_val("rd_rsp_data", 64'(rsp_data), 64'h1234_5678);
    check_val("rd_rsp_err", 64'(rsp_err), 64'd0);
    check_val("rd_req_drop", 64'(m_req), 64'd0);
    m_din = '0;
    @(negedge clk);
    check_val("rd_rsp_once", 64'(rsp_valid), 64'd0);
    check_val("rd_rsp_hold", 64'(rsp_data), 64'h1234_5678);

    // Wait on d_interrupt; a_interrupt high must not satisfy it
    a_interrupt = 1'b1;
    push_cmd(2'b11, 16'h0, 32'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seen += int'(rsp_valid);
      @(negedge clk);
    end
    check_val("irqd_early", 64'(seen), 64'd0);
    check_val("irqd_busy", 64'(busy), 64'd1);
    d_interrupt = 1'b1;
    @(negedge clk);
    check_val("irqd_rsp", 64'(rsp_valid), 64'd1);
    check_val("irqd_data", 64'(rsp_data), 64'd0);
    check_val("irqd_err", 64'(rsp_err), 64'd0);
    d_interrupt = 1'b0;
    @(negedge clk);
    check_val("irqd_once", 64'(rsp_valid), 64'd0);

    // Wait on a_interrupt that is already high
    push_cmd(2'b10, 16'h0, 32'h0);
    check_val("irqa_n1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check_val("irqa_n2", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check_val("irqa_rsp", 64'(rsp_valid), 64'd1);
    check_val("irqa_err", 64'(rsp_err), 64'd0);
    a_interrupt = 1'b0;
    @(negedge clk);

    // Interrupt wait with no interrupt
`ifdef BCM_IRQ_TIMEOUT_EN
    push_cmd(2'b10, 16'h0, 32'h0);
    cnt = 1;
    while (!rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_val("tmo_latency", 64'(cnt), 64'd10);
    check_val("tmo_err", 64'(rsp_err), 64'd1);
    check_val("tmo_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    check_val("tmo_idle", 64'(busy), 64'd0);
`else
    push_cmd(2'b10, 16'h0, 32'h0);
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    check_val("notmo_no_rsp", 64'(seen), 64'd0);
    check_val("notmo_busy", 64'(busy), 64'd1);
    a_interrupt = 1'b1;
    @(negedge clk);
    check_val("notmo_rsp", 64'(rsp_valid), 64'd1);
    check_val("notmo_err", 64'(rsp_err), 64'd0);
    a_interrupt = 1'b0;
    @(negedge clk);
`endif

    // FIFO full with the bus stalled, then drain in push order
    m_grant = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(2'b00, AW'(16'h0100 + i), DW'(i));
    check_val("full_ready", 64'(cmd_ready), 64'd0);
    check_val("full_busy", 64'(busy), 64'd1);
    cmd_op    = 2'b00;
    cmd_addr  = 16'h0105;
    cmd_data  = 32'd5;
    cmd_valid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(cmd_ready);
    end
    check_val("full_hold", 64'(seen), 64'd0);
    bus_log.delete();
    auto_slv = 1'b1;
    push_cmd(2'b00, 16'h0105, 32'd5);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("full_drain", 64'(busy), 64'd0);
    check_val("full_log_len", 64'(bus_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < bus_log.size(); i++) begin
      check_val("full_order", 64'(bus_log[i]), 64'(16'h0100 + i));
    end
    auto_slv = 1'b0;
    @(negedge clk);
    m_grant = 1'b0;
    a_interrupt = 1'b0;
    d_interrupt = 1'b0;

    // Reset while in RDWAIT with another command queued
    push_cmd(2'b01, 16'h0030, 32'h0);
    push_cmd(2'b01, 16'h0040, 32'h0);
    wait_req(20);
    m_grant = 1'b1;
    @(negedge clk);
    check_val("rst_mid_rdwait", 64'(m_req), 64'd1);
    m_grant = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check_val("rst_mid_req", 64'(m_req), 64'd0);
    check_val("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    check_val("rst_mid_busy", 64'(busy), 64'd0);
    check_val("rst_mid_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(rsp_valid | m_req | busy);
    end
    check_val("rst_mid_quiet", 64'(seen), 64'd0);

    // Random commands against the reference model
    slv_mem.delete();
    mdl_mem.delete();
    exp_q.delete();
    exp_total = 0;
    n_rsp = 0;
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    auto_slv = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push_cmd(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], DW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_val("rand_idle", 64'(busy), 64'd0);
    check_val("rand_pending", 64'(exp_q.size()), 64'd0);
    check_val("rand_rsp_count", 64'(n_rsp), 64'(exp_total));
    mon_en   = 1'b0;
    auto_slv = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
